tt_sweep_ctrl: RTL and testbench

TT_SWEEP_CTRL -- requirements
Module: tt_sweep_ctrl

---
 rtl/tt_sweep_ctrl.sv | 153 +++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_ctrl.sv
// ============================================================================
// tt_sweep_ctrl -- sweeps a 4-input logic block through all 16 input vectors,
// captures each 3-bit response and scores it against a loadable expected table.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tt_sweep_ctrl #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic [3:0] dut_in,
  input  logic [2:0] dut_out,
  input  logic       exp_wr_en,
  input  logic [3:0] exp_wr_addr,
  input  logic [2:0] exp_wr_data,
  input  logic [3:0] rd_addr,
  output logic [2:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       table_valid,
  output logic [4:0] mismatch_cnt,
  output logic       pass
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRIVE   = 3'd1,
    S_SETTLE  = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] idx;
  logic [3:0] settle_cnt;
  logic [2:0] exp_tbl [16];
  logic [2:0] cap_tbl [16];

  logic sweep_go;
  logic drive_en;
  logic capture_en;
  logic finish_en;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Abort takes effect from any active sweep state except DONE, where completion wins.
  always_comb begin
    state_nxt  = state;
    sweep_go   = 1'b0;
    drive_en   = 1'b0;
    capture_en = 1'b0;
    finish_en  = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start && !abort) begin
          sweep_go  = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          drive_en  = 1'b1;
          state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (abort)                          state_nxt = S_IDLE;
        else if (settle_cnt == SETTLE_LAST) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (abort) begin
          state_nxt = S_IDLE;
        end else begin
          capture_en = 1'b1;
          state_nxt  = (idx == 4'd15) ? S_DONE : S_DRIVE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        finish_en = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx          <= 4'd0;
      settle_cnt   <= 4'd0;
      dut_in       <= 4'd0;
      mismatch_cnt <= 5'd0;
      table_valid  <= 1'b0;
      pass         <= 1'b0;
    end else begin
      if (sweep_go) begin
        idx          <= 4'd0;
        mismatch_cnt <= 5'd0;
        table_valid  <= 1'b0;
        pass         <= 1'b0;
      end
      if (drive_en) begin
        dut_in     <= idx;
        settle_cnt <= 4'd0;
      end
      if (state == S_SETTLE) settle_cnt <= settle_cnt + 4'd1;
      if (capture_en) begin
        if (dut_out != exp_tbl[idx]) mismatch_cnt <= mismatch_cnt + 5'd1;
        if (idx != 4'd15)            idx          <= idx + 4'd1;
      end
      if (finish_en) begin
        table_valid <= 1'b1;
        pass        <= (mismatch_cnt == 5'd0);
      end
    end
  end

  // Expected table is only writable between sweeps so a sweep scores against a stable reference.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) exp_tbl[i] <= 3'b000;
    end else if (exp_wr_en && (state == S_IDLE)) begin
      exp_tbl[exp_wr_addr] <= exp_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && capture_en) cap_tbl[idx] <= dut_out;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data <= 3'b000;
    else        rd_data <= cap_tbl[rd_addr];
  end

endmodule

`default_nettype wire

// File: tb/tb_tt_sweep_ctrl.sv
// ============================================================================
// tb_tt_sweep_ctrl -- randomized self-checking bench for tt_sweep_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tt_sweep_ctrl;

  localparam int S  = 2;
  localparam int S1 = 1;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, exp_wr_en;
  logic [3:0] exp_wr_addr, rd_addr;
  logic [2:0] exp_wr_data;
  logic [3:0] dut_in, dut_in1;
  logic [2:0] dut_out, dut_out1, rd_data, rd_data1;
  logic       busy, done, table_valid, pass;
  logic       busy1, done1, table_valid1, pass1;
  logic [4:0] mismatch_cnt, mismatch_cnt1;

  logic [2:0] resp_tbl  [16];
  logic [2:0] exp_model [16];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign dut_out  = resp_tbl[dut_in];
  assign dut_out1 = resp_tbl[dut_in1];

  tt_sweep_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .done(done), .table_valid(table_valid),
    .mismatch_cnt(mismatch_cnt), .pass(pass)
  );

  tt_sweep_ctrl #(.SETTLE_CYCLES(S1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .dut_in(dut_in1), .dut_out(dut_out1),
    .exp_wr_en(exp_wr_en), .exp_wr_addr(exp_wr_addr), .exp_wr_data(exp_wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data1),
    .busy(busy1), .done(done1), .table_valid(table_valid1),
    .mismatch_cnt(mismatch_cnt1), .pass(pass1)
  );

  function automatic logic [2:0] golden(input logic [3:0] v);
    if (v[3:2] == 2'b11)  return 3'b100;
    if (v[3:1] == 3'b101) return 3'b010;
    if (v == 4'b1001)     return 3'b001;
    return 3'b000;
  endfunction

  function automatic int model_mismatch(input int upto);
    int m = 0;
    for (int v = 0; v < upto; v++) if (resp_tbl[v] != exp_model[v]) m++;
    return m;
  endfunction

  task automatic write_exp_all();
    for (int v = 0; v < 16; v++) begin
      exp_wr_en   = 1'b1;
      exp_wr_addr = 4'(v);
      exp_wr_data = exp_model[v];
      @(negedge clk);
    end
    exp_wr_en = 1'b0;
  endtask

  task automatic load_golden();
    for (int v = 0; v < 16; v++) begin
      exp_model[v] = golden(4'(v));
      resp_tbl[v]  = golden(4'(v));
    end
    write_exp_all();
  endtask

  task automatic read_check(input int a, input logic [2:0] want, input string name);
    rd_addr = 4'(a);
    @(negedge clk);
    vectors++;
    if (rd_data !== want) begin
      miscompares++;
      $display("FAIL %s rd[%0d]: got %b expected %b", name, a, rd_data, want);
    end
  endtask

  // Pulses start, then returns at the negedge where done is first seen.
  task automatic wait_done(input string name);
    int n = 0;
    bit seen = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    vectors++;
    if (!seen || n != 16 * (S + 2)) begin
      miscompares++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, seen ? n : -1, 16 * (S + 2));
    end
  endtask

  task automatic check_result(input string name);
    int m = model_mismatch(16);
    @(negedge clk);
    vectors++;
    if (table_valid !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s status: got tv=%b busy=%b done=%b expected 1 0 0", name, table_valid, busy, done);
    end
    vectors++;
    if (mismatch_cnt !== 5'(m) || pass !== (m == 0)) begin
      miscompares++;
      $display("FAIL %s score: got cnt=%0d pass=%b expected cnt=%0d pass=%b", name, mismatch_cnt, pass, m, m == 0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; abort = 1'b1;
    exp_wr_en = 1'b0; exp_wr_addr = '0; exp_wr_data = '0; rd_addr = '0;
    for (int v = 0; v < 16; v++) begin exp_model[v] = 3'b000; resp_tbl[v] = 3'b000; end
    repeat (3) @(negedge clk);
    vectors++;
    if ({busy, done, table_valid, pass, mismatch_cnt, dut_in, rd_data} !== 16'd0 ||
        {busy1, done1, table_valid1, pass1, mismatch_cnt1, dut_in1, rd_data1} !== 16'd0) begin
      miscompares++;
      $display("FAIL reset outputs: got busy=%b done=%b tv=%b pass=%b cnt=%0d in=%h rd=%b expected all zero",
               busy, done, table_valid, pass, mismatch_cnt, dut_in, rd_data);
    end
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset idle_after_release: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_golden();
    load_golden();
    wait_done("golden");
    check_result("golden");
    read_check(12, 3'b100, "golden");
    vectors++;
    if (dut_in !== 4'hF) begin
      miscompares++;
      $display("FAIL golden dut_in_hold: got %h expected f", dut_in);
    end
  endtask

  task automatic test_single_fault();
    resp_tbl[5] = 3'b011;
    wait_done("fault5");
    check_result("fault5");
    read_check(5, 3'b011, "fault5");
    resp_tbl[5] = golden(4'd5);
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      for (int v = 0; v < 16; v++) begin
        exp_model[v] = 3'($urandom_range(7));
        resp_tbl[v]  = ($urandom_range(3) == 0) ? 3'($urandom_range(7)) : exp_model[v];
      end
      write_exp_all();
      wait_done("random");
      check_result("random");
      for (int v = 0; v < 16; v++) read_check(v, resp_tbl[v], "random");
    end
  endtask

  task automatic test_abort();
    int n = 0;
    int dones = 0;
    // start and abort together in idle must not launch a sweep
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort start_and_abort: got busy=%b expected 0", busy);
    end
    for (int v = 0; v < 16; v++) resp_tbl[v] = 3'($urandom_range(7));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    // vector 7 settles in the cycles after edges 29 and 30 with S=2
    while (n < 29) begin @(negedge clk); n++; end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++;
    if (busy !== 1'b0 || dut_in !== 4'd7) begin
      miscompares++;
      $display("FAIL abort stop: got busy=%b dut_in=%0d expected 0 7", busy, dut_in);
    end
    repeat (20) begin @(negedge clk); if (done) dones++; end
    vectors++;
    if (dones != 0 || table_valid !== 1'b0 || pass !== 1'b0) begin
      miscompares++;
      $display("FAIL abort aftermath: got dones=%0d tv=%b pass=%b expected 0 0 0", dones, table_valid, pass);
    end
    vectors++;
    if (mismatch_cnt !== 5'(model_mismatch(7))) begin
      miscompares++;
      $display("FAIL abort partial_cnt: got %0d expected %0d", mismatch_cnt, model_mismatch(7));
    end
    for (int v = 0; v < 7; v++) read_check(v, resp_tbl[v], "abort");
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int first = -1;
    int pulses = 0;
    load_golden();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (n < 100) begin
      if (n == 20) begin
        start = 1'b1; exp_wr_en = 1'b1; exp_wr_addr = 4'd12; exp_wr_data = 3'b000;
      end
      @(negedge clk);
      n++;
      start = 1'b0; exp_wr_en = 1'b0;
      if (done) begin pulses++; if (first < 0) first = n; end
    end
    vectors++;
    if (first != 16 * (S + 2) || pulses != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b done: got first=%0d pulses=%0d busy=%b expected %0d 1 0", first, pulses, busy, 16 * (S + 2));
    end
    vectors++;
    if (mismatch_cnt !== 5'd0 || pass !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b score: got cnt=%0d pass=%b expected 0 1", mismatch_cnt, pass);
    end
    wait_done("b2b_rerun");
    check_result("b2b_rerun");
  endtask

  task automatic test_reset_mid_sweep();
    int n = 0;
    int f0 = -1, f1 = -1, p0 = 0, p1 = 0;
    load_golden();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (n < 30) begin @(negedge clk); n++; end
    rst_n = 1'b0; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, done, table_valid, pass, mismatch_cnt, dut_in, rd_data} !== 16'd0 ||
        {busy1, done1, table_valid1, pass1, mismatch_cnt1, dut_in1, rd_data1} !== 16'd0) begin
      miscompares++;
      $display("FAIL midreset outputs: got busy=%b done=%b tv=%b cnt=%0d in=%h rd=%b expected all zero",
               busy, done, table_valid, mismatch_cnt, dut_in, rd_data);
    end
    start = 1'b0; abort = 1'b0; rst_n = 1'b1;
    for (int v = 0; v < 16; v++) exp_model[v] = 3'b000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (n < 80) begin
      @(negedge clk);
      n++;
      if (done)  begin p0++; if (f0 < 0) f0 = n; end
      if (done1) begin p1++; if (f1 < 0) f1 = n; end
    end
    vectors++;
    if (f0 != 16 * (S + 2) || f1 != 16 * (S1 + 2) || p0 != 1 || p1 != 1) begin
      miscompares++;
      $display("FAIL midreset done: got %0d/%0d pulses %0d/%0d expected %0d/%0d 1/1",
               f0, f1, p0, p1, 16 * (S + 2), 16 * (S1 + 2));
    end
    vectors++;
    if (mismatch_cnt !== 5'(model_mismatch(16)) || mismatch_cnt1 !== 5'(model_mismatch(16)) ||
        table_valid1 !== 1'b1 || pass1 !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset score: got %0d/%0d tv1=%b pass1=%b expected %0d 1 0",
               mismatch_cnt, mismatch_cnt1, table_valid1, pass1, model_mismatch(16));
    end
  endtask

  initial begin
    test_reset();
    test_golden();
    test_single_fault();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
